// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares the single line-wide L2/memory request port between the D-cache
// (requester 0) and I-cache (requester 1) miss FSMs. Grants round-robin,
// holds the winning request in local registers for the whole transaction,
// steers the completion back to the owner only and counts grants per side.
module l2_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic              req0_rw_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LINE_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  output logic [LINE_W-1:0] req0_rdata_o,
  input  logic              req1_valid_i,
  input  logic              req1_rw_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LINE_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic [LINE_W-1:0] req1_rdata_o,
  output logic              mem_valid_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              owner_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  grant0_cnt_o,
  output logic [CNT_W-1:0]  grant1_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic              abort_q, abort_d;
  logic              owner_q;
  logic              last_grant_q;
  logic              grant_en;
  logic              grant_sel;
  logic              owner_valid;
  logic              done;
  logic              lat_rw_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [LINE_W-1:0] lat_wdata_q;
  logic [CNT_W-1:0]  grant0_cnt;
  logic [CNT_W-1:0]  grant1_cnt;

  assign owner_valid = owner_q ? req1_valid_i : req0_valid_i;
  assign done        = (state_q == BUSY) && mem_ready_i;

  // Next-state, grant selection and abort tracking
  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    grant_en  = 1'b0;
    grant_sel = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
          grant_en  = 1'b1;
          grant_sel = ~last_grant_q;
        end else if (req0_valid_i) begin
          grant_en  = 1'b1;
          grant_sel = 1'b0;
        end else if (req1_valid_i) begin
          grant_en  = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant_en) state_d = BUSY;
      end
      BUSY: begin
        if (mem_ready_i) begin
          // Completion always returns to IDLE, giving the mandatory gap cycle
          state_d = IDLE;
          abort_d = 1'b0;
        end else if (!owner_valid) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register and abort flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Latch the winning request, record ownership and count grants
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lat_rw_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
    end else if (grant_en) begin
      owner_q      <= grant_sel;
      last_grant_q <= grant_sel;
      lat_rw_q     <= grant_sel ? req1_rw_i    : req0_rw_i;
      lat_addr_q   <= grant_sel ? req1_addr_i  : req0_addr_i;
      lat_wdata_q  <= grant_sel ? req1_wdata_i : req0_wdata_i;
      if (grant_sel) grant1_cnt <= grant1_cnt + CNT_ONE;
      else           grant0_cnt <= grant0_cnt + CNT_ONE;
    end
  end

  // Downstream port is driven purely from the latches while BUSY
  assign mem_valid_o  = (state_q == BUSY);
  assign mem_rw_o     = lat_rw_q;
  assign mem_addr_o   = lat_addr_q;
  assign mem_wdata_o  = lat_wdata_q;
  assign busy_o       = (state_q == BUSY);
  assign owner_o      = owner_q;
  assign grant0_cnt_o = grant0_cnt;
  assign grant1_cnt_o = grant1_cnt;

  // Completion reaches the owner only; an aborted owner's ready is swallowed
  assign req0_ready_o = done && !owner_q && !abort_q;
  assign req1_ready_o = done &&  owner_q && !abort_q;
  assign req0_rdata_o = (done && !owner_q) ? mem_rdata_i : '0;
  assign req1_rdata_o = (done &&  owner_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter
// Directed scenarios plus a randomized run, all checked every cycle against a
// transaction-level model of the arbiter kept in the bench.
module tb_l2_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int CW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req0_valid_i, req0_rw_i, req1_valid_i, req1_rw_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [LW-1:0] req0_wdata_i, req1_wdata_i;
  logic          req0_ready_o, req1_ready_o;
  logic [LW-1:0] req0_rdata_o, req1_rdata_o;
  logic          mem_valid_o, mem_rw_o, mem_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o, mem_rdata_i;
  logic          owner_o, busy_o;
  logic [CW-1:0] grant0_cnt_o, grant1_cnt_o;

  l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_rw_i(req0_rw_i), .req0_addr_i(req0_addr_i),
    .req0_wdata_i(req0_wdata_i), .req0_ready_o(req0_ready_o), .req0_rdata_o(req0_rdata_o),
    .req1_valid_i(req1_valid_i), .req1_rw_i(req1_rw_i), .req1_addr_i(req1_addr_i),
    .req1_wdata_i(req1_wdata_i), .req1_ready_o(req1_ready_o), .req1_rdata_o(req1_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .owner_o(owner_o), .busy_o(busy_o),
    .grant0_cnt_o(grant0_cnt_o), .grant1_cnt_o(grant1_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [CW-1:0] off1 = '0;   // offset mirroring a forced preload of the grant1 counter

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding transaction at most: who owns it, what it carries,
  // whether its owner gave up on it, and the grant history.
  logic          m_busy, m_owner, m_last, m_abort, m_rw;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic [CW-1:0] m_cnt [2];

  always @(posedge clk_i or posedge rst_i) begin
    int w;
    if (rst_i) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1; m_abort <= 1'b0;
      m_rw <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_cnt[0] <= '0; m_cnt[1] <= '0;
    end else if (!m_busy) begin
      w = -1;
      if (req0_valid_i && req1_valid_i) w = m_last ? 0 : 1;
      else if (req0_valid_i)            w = 0;
      else if (req1_valid_i)            w = 1;
      if (w >= 0) begin
        m_busy  <= 1'b1;
        m_abort <= 1'b0;
        m_owner <= (w == 1);
        m_last  <= (w == 1);
        m_rw    <= (w == 1) ? req1_rw_i    : req0_rw_i;
        m_addr  <= (w == 1) ? req1_addr_i  : req0_addr_i;
        m_wdata <= (w == 1) ? req1_wdata_i : req0_wdata_i;
        m_cnt[w] <= m_cnt[w] + 1;
      end
    end else begin
      if (mem_ready_i) begin
        m_busy  <= 1'b0;
        m_abort <= 1'b0;
      end else if (!(m_owner ? req1_valid_i : req0_valid_i)) begin
        m_abort <= 1'b1;
      end
    end
  end

  // Compare every output against the model once per cycle
  always @(negedge clk_i) begin
    logic fin0, fin1;
    if (chk_en) begin
      fin0 = m_busy && mem_ready_i && !m_owner;
      fin1 = m_busy && mem_ready_i &&  m_owner;
      chk("mem_valid", LW'(mem_valid_o), LW'(m_busy));
      chk("busy", LW'(busy_o), LW'(m_busy));
      chk("owner", LW'(owner_o), LW'(m_owner));
      chk("mem_rw", LW'(mem_rw_o), LW'(m_rw));
      chk("mem_addr", LW'(mem_addr_o), LW'(m_addr));
      chk("mem_wdata", mem_wdata_o, m_wdata);
      chk("ready0", LW'(req0_ready_o), LW'(fin0 && !m_abort));
      chk("ready1", LW'(req1_ready_o), LW'(fin1 && !m_abort));
      chk("rdata0", req0_rdata_o, fin0 ? mem_rdata_i : '0);
      chk("rdata1", req1_rdata_o, fin1 ? mem_rdata_i : '0);
      chk("grant0_cnt", LW'(grant0_cnt_o), LW'(m_cnt[0]));
      chk("grant1_cnt", LW'(grant1_cnt_o), LW'(CW'(m_cnt[1] + off1)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid_i = 0; req0_rw_i = 0; req0_addr_i = '0; req0_wdata_i = '0;
    req1_valid_i = 0; req1_rw_i = 0; req1_addr_i = '0; req1_wdata_i = '0;
    mem_ready_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    clear_inputs();
    off1 = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic serve;
    mem_ready_i = 1'b1;
    mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
    tick();
    mem_ready_i = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] line1;
    logic [LW-1:0] wb_line;
    line1   = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    wb_line = {4{32'h1111_1111}};
    do_reset();
    chk("rst_mem_valid", LW'(mem_valid_o), '0);
    chk("rst_grant0", LW'(grant0_cnt_o), '0);
    chk_en = 1'b1;

    // 1: single read from requester 0
    req0_addr_i = 32'h0000_1040; req0_rw_i = 0; req0_valid_i = 1;
    #1 chk("t1_no_valid_same_cycle", LW'(mem_valid_o), '0);
    tick();
    chk("t1_mem_valid", LW'(mem_valid_o), LW'(1));
    chk("t1_addr", LW'(mem_addr_o), LW'(32'h0000_1040));
    chk("t1_rw", LW'(mem_rw_o), '0);
    tick(); tick();
    mem_ready_i = 1; mem_rdata_i = line1;
    #1;
    chk("t1_ready0", LW'(req0_ready_o), LW'(1));
    chk("t1_rdata0", req0_rdata_o, line1);
    chk("t1_ready1", LW'(req1_ready_o), '0);
    tick();
    mem_ready_i = 0; req0_valid_i = 0;
    chk("t1_gap", LW'(mem_valid_o), '0);
    chk("t1_grant0", LW'(grant0_cnt_o), LW'(1));
    tick();

    // 2: round-robin under contention
    do_reset();
    req0_addr_i = 32'hA000; req1_addr_i = 32'hB000;
    req0_valid_i = 1; req1_valid_i = 1;
    tick();
    chk("t2_owner_a", LW'(owner_o), '0);
    chk("t2_g0_a", LW'(grant0_cnt_o), LW'(1));
    serve();
    chk("t2_gap_a", LW'(mem_valid_o), '0);
    tick();
    chk("t2_owner_b", LW'(owner_o), LW'(1));
    chk("t2_g1_b", LW'(grant1_cnt_o), LW'(1));
    chk("t2_addr_b", LW'(mem_addr_o), LW'(32'hB000));
    serve();
    tick();
    chk("t2_owner_c", LW'(owner_o), '0);
    chk("t2_g0_c", LW'(grant0_cnt_o), LW'(2));
    req0_valid_i = 0; req1_valid_i = 0;
    serve();
    tick();

    // 3: write-back then allocate from requester 0, interleaved with requester 1
    do_reset();
    req0_rw_i = 1; req0_addr_i = 32'h2000; req0_wdata_i = wb_line; req0_valid_i = 1;
    tick();
    chk("t3_wb_rw", LW'(mem_rw_o), LW'(1));
    chk("t3_wb_wdata", mem_wdata_o, wb_line);
    req0_rw_i = 0; req0_addr_i = 32'h3000;
    req1_valid_i = 1; req1_addr_i = 32'h5000; req1_rw_i = 0;
    tick();
    chk("t3_wb_addr_stable", LW'(mem_addr_o), LW'(32'h2000));
    serve();
    tick();
    chk("t3_owner_i", LW'(owner_o), LW'(1));
    chk("t3_addr_i", LW'(mem_addr_o), LW'(32'h5000));
    serve();
    req1_valid_i = 0;
    tick();
    chk("t3_owner_alloc", LW'(owner_o), '0);
    chk("t3_addr_alloc", LW'(mem_addr_o), LW'(32'h3000));
    chk("t3_g0", LW'(grant0_cnt_o), LW'(2));
    req0_valid_i = 0;
    serve();
    tick();

    // 4: latch stability and abort
    do_reset();
    req0_addr_i = 32'h4000; req0_valid_i = 1;
    tick();
    req0_addr_i = 32'hFFFF_0000;
    tick();
    chk("t4_addr_stable", LW'(mem_addr_o), LW'(32'h4000));
    req0_valid_i = 0;
    tick();
    mem_ready_i = 1;
    #1;
    chk("t4_ready_swallowed", LW'(req0_ready_o), '0);
    chk("t4_busy", LW'(busy_o), LW'(1));
    tick();
    mem_ready_i = 0;
    chk("t4_idle", LW'(busy_o), '0);
    tick();

    // 5: asynchronous reset in the middle of a transaction
    do_reset();
    req1_addr_i = 32'h6000; req1_valid_i = 1;
    tick();
    chk("t5_busy", LW'(busy_o), LW'(1));
    #2;
    mem_ready_i = 1; rst_i = 1;
    #1;
    chk("t5_mem_valid", LW'(mem_valid_o), '0);
    chk("t5_busy_rst", LW'(busy_o), '0);
    chk("t5_g1", LW'(grant1_cnt_o), '0);
    chk("t5_ready1", LW'(req1_ready_o), '0);
    req1_valid_i = 0; mem_ready_i = 0;
    tick();
    rst_i = 0;
    tick();

    // 6: grant counter wrap
    do_reset();
    force dut.grant1_cnt = '1;
    off1 = '1;
    #1;
    release dut.grant1_cnt;
    chk("t6_preload", LW'(grant1_cnt_o), LW'(32'hFFFF_FFFF));
    req1_valid_i = 1;
    tick();
    chk("t6_wrap", LW'(grant1_cnt_o), '0);
    req1_valid_i = 0;
    serve();
    tick();

    // randomized traffic
    do_reset();
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) req0_valid_i = ~req0_valid_i;
      if ($urandom_range(0, 3) == 0) req1_valid_i = ~req1_valid_i;
      req0_rw_i = 1'($urandom_range(0, 1));
      req1_rw_i = 1'($urandom_range(0, 1));
      req0_addr_i = $urandom;
      req1_addr_i = $urandom;
      req0_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      req1_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      mem_ready_i = ($urandom_range(0, 3) == 0);
      mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    clear_inputs();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
